// File: rtl/sysid_regfile.sv
// rtl/sysid_regfile.sv - system identification slave: ID, timestamp, caps, uptime, scratch
// Uptime counter, prescaler and high-word snapshot exist only when SYSID_UPTIME_EN is defined.
module sysid_regfile #(
  parameter logic [31:0] ID_VALUE    = 32'h5A8C_F03F,
  parameter logic [31:0] TIMESTAMP   = 32'h0000_0000,
  parameter int          ADDR_WIDTH  = 4,
  parameter int          NUM_SCRATCH = 4,
  parameter int          TICK_DIV    = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic                  read,
  input  logic                  write,
  input  logic [31:0]           writedata,
  input  logic [3:0]            byteenable,
  output logic [31:0]           readdata,
  output logic                  readdatavalid
);

  localparam logic [ADDR_WIDTH-1:0] A_ID    = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] A_TS    = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] A_CAPS  = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] A_UP_LO = ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] A_UP_HI = ADDR_WIDTH'(4);

`ifdef SYSID_UPTIME_EN
  localparam logic UPTIME_BIT = 1'b1;
`else
  localparam logic UPTIME_BIT = 1'b0;
`endif

  localparam logic [31:0] CAPS = {16'(TICK_DIV), 4'h0, 4'(NUM_SCRATCH), 7'h0, UPTIME_BIT};

  logic [31:0] readdata_q;
  logic        readdatavalid_q;
  logic [31:0] rd_mux;
  logic [31:0] scratch_q [NUM_SCRATCH];
  logic [31:0] scratch_d [NUM_SCRATCH];
  logic [31:0] up_lo;
  logic [31:0] up_hi;

`ifdef SYSID_UPTIME_EN
  logic [63:0] uptime_q, uptime_d;
  logic [15:0] presc_q, presc_d;
  logic [31:0] hi_snap_q, hi_snap_d;

  always_comb begin
    uptime_d  = uptime_q;
    presc_d   = presc_q;
    hi_snap_d = hi_snap_q;
    if (presc_q == 16'(TICK_DIV - 1)) begin
      presc_d  = 16'd0;
      uptime_d = uptime_q + 64'd1;
    end else begin
      presc_d = presc_q + 16'd1;
    end
    // A clear wins over a tick landing in the same cycle
    if (write && address == A_UP_LO) begin
      presc_d  = 16'd0;
      uptime_d = 64'd0;
    end
    if (read && address == A_UP_LO) begin
      hi_snap_d = uptime_q[63:32];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      uptime_q  <= 64'd0;
      presc_q   <= 16'd0;
      hi_snap_q <= 32'd0;
    end else begin
      uptime_q  <= uptime_d;
      presc_q   <= presc_d;
      hi_snap_q <= hi_snap_d;
    end
  end

  assign up_lo = uptime_q[31:0];
  assign up_hi = hi_snap_q;
`else
  assign up_lo = 32'd0;
  assign up_hi = 32'd0;
`endif

  always_comb begin
    scratch_d = scratch_q;
    for (int i = 0; i < NUM_SCRATCH; i++) begin
      if (write && address == ADDR_WIDTH'(8 + i)) begin
        for (int b = 0; b < 4; b++) begin
          if (byteenable[b]) scratch_d[i][8*b +: 8] = writedata[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    rd_mux = 32'd0;
    case (address)
      A_ID:    rd_mux = ID_VALUE;
      A_TS:    rd_mux = TIMESTAMP;
      A_CAPS:  rd_mux = CAPS;
      A_UP_LO: rd_mux = up_lo;
      A_UP_HI: rd_mux = up_hi;
      default: rd_mux = 32'd0;
    endcase
    for (int i = 0; i < NUM_SCRATCH; i++) begin
      if (address == ADDR_WIDTH'(8 + i)) rd_mux = scratch_q[i];
    end
  end

  // Read data comes from pre-write state, so a same-cycle write is not visible
  always_ff @(posedge clock) begin
    if (reset) begin
      readdata_q      <= 32'd0;
      readdatavalid_q <= 1'b0;
      scratch_q       <= '{default: 32'd0};
    end else begin
      readdata_q      <= read ? rd_mux : 32'd0;
      readdatavalid_q <= read;
      scratch_q       <= scratch_d;
    end
  end

  assign readdata      = readdata_q;
  assign readdatavalid = readdatavalid_q;

endmodule

// File: tb/tb_sysid_regfile.sv
// tb/tb_sysid_regfile.sv - scoreboard bench for sysid_regfile (two parameterisations)
module tb_sysid_regfile;

  typedef struct {
    logic [31:0] data;
    int          cyc;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  address1, address2;
  logic        read1, read2, write1, write2;
  logic [31:0] wdata1, wdata2;
  logic [3:0]  be1, be2;
  logic [31:0] rdata1, rdata2;
  logic        valid1, valid2;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q1[$];
  exp_t q2[$];

`ifdef SYSID_UPTIME_EN
  localparam bit UP = 1'b1;
`else
  localparam bit UP = 1'b0;
`endif

  sysid_regfile dut1 (
    .clock(clk), .reset(reset), .address(address1), .read(read1), .write(write1),
    .writedata(wdata1), .byteenable(be1), .readdata(rdata1), .readdatavalid(valid1)
  );

  sysid_regfile #(.NUM_SCRATCH(2), .TICK_DIV(4)) dut2 (
    .clock(clk), .reset(reset), .address(address2), .read(read2), .write(write2),
    .writedata(wdata2), .byteenable(be2), .readdata(rdata2), .readdatavalid(valid2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (valid1) begin
      if (q1.size() == 0) chk("dut1 unexpected beat", 32'd1, 32'd0);
      else begin
        e = q1.pop_front();
        chk(e.name, rdata1, e.data);
        chk({e.name, " latency"}, cyc, e.cyc + 1);
      end
    end
    if (valid2) begin
      if (q2.size() == 0) chk("dut2 unexpected beat", 32'd1, 32'd0);
      else begin
        e = q2.pop_front();
        chk(e.name, rdata2, e.data);
        chk({e.name, " latency"}, cyc, e.cyc + 1);
      end
    end
  end

  // One bus cycle on dut1, entered and left at a falling edge
  task automatic bus1(input bit rd, input bit wr, input logic [3:0] a, input logic [31:0] wd,
                      input logic [3:0] be, input logic [31:0] exp, input string name);
    address1 = a; read1 = rd; write1 = wr; wdata1 = wd; be1 = be;
    if (rd) q1.push_back('{exp, cyc, name});
    @(negedge clk);
    read1 = 1'b0; write1 = 1'b0;
  endtask

  task automatic bus2(input bit rd, input bit wr, input logic [3:0] a, input logic [31:0] wd,
                      input logic [3:0] be, input logic [31:0] exp, input string name);
    address2 = a; read2 = rd; write2 = wr; wdata2 = wd; be2 = be;
    if (rd) q2.push_back('{exp, cyc, name});
    @(negedge clk);
    read2 = 1'b0; write2 = 1'b0;
  endtask

  initial begin
    int rel;
    reset = 1'b1;
    address1 = '0; read1 = 1'b0; write1 = 1'b0; wdata1 = '0; be1 = '0;
    address2 = '0; read2 = 1'b0; write2 = 1'b0; wdata2 = '0; be2 = '0;
    repeat (3) @(negedge clk);
    chk("reset readdata1", rdata1, 32'd0);
    chk("reset valid1", {31'd0, valid1}, 32'd0);
    chk("reset readdata2", rdata2, 32'd0);
    chk("reset valid2", {31'd0, valid2}, 32'd0);
    reset = 1'b0;
    rel = cyc;

    // ID / caps / unmapped, back to back
    bus1(1, 0, 4'd0, 0, 0, 32'h5A8C_F03F, "id");
    bus1(1, 0, 4'd2, 0, 0, {31'h0000_8200, UP}, "caps");
    bus1(1, 0, 4'd5, 0, 0, 32'd0, "word5");
    bus1(1, 0, 4'd1, 0, 0, 32'd0, "timestamp");
    bus1(1, 0, 4'd4, 0, 0, 32'd0, "snap after reset");

    // Scratch byte lanes and out-of-range scratch
    bus1(0, 1, 4'd8, 32'hDEAD_BEEF, 4'hF, 0, "");
    bus1(0, 1, 4'd8, 32'h1122_3344, 4'b0101, 0, "");
    bus1(1, 0, 4'd8, 0, 0, 32'hDE22_BE44, "scratch8 lanes");
    bus1(0, 1, 4'd8, 32'h0000_0000, 4'h0, 0, "");
    bus1(1, 0, 4'd8, 0, 0, 32'hDE22_BE44, "scratch8 be0");
    bus1(1, 0, 4'd9, 0, 0, 32'd0, "scratch9 init");
    bus1(0, 1, 4'd12, 32'hFFFF_FFFF, 4'hF, 0, "");
    bus1(1, 0, 4'd12, 0, 0, 32'd0, "word12 after write");

    // Same-cycle read/write
    bus1(0, 1, 4'd9, 32'h0000_00AA, 4'hF, 0, "");
    bus1(1, 1, 4'd9, 32'h0000_0055, 4'hF, 32'h0000_00AA, "rw same cycle old");
    bus1(1, 0, 4'd9, 0, 0, 32'h0000_0055, "rw same cycle new");

    // Prescaled uptime on dut2: read sampled after exactly 40 unreset edges
    while (cyc < rel + 40) @(negedge clk);
    bus2(1, 0, 4'd3, 0, 0, UP ? 32'd10 : 32'd0, "prescaled uptime");
    bus2(0, 1, 4'd3, 32'h1234_5678, 4'h0, 0, "");
    bus2(1, 0, 4'd3, 0, 0, 32'd0, "uptime after clear");
    bus2(1, 0, 4'd2, 0, 0, {31'h0002_0100, UP}, "caps dut2");
    bus2(0, 1, 4'd9, 32'hCAFE_F00D, 4'hF, 0, "");
    bus2(0, 1, 4'd10, 32'hCAFE_F00D, 4'hF, 0, "");
    bus2(1, 0, 4'd9, 0, 0, 32'hCAFE_F00D, "dut2 last scratch");
    bus2(1, 0, 4'd10, 0, 0, 32'd0, "dut2 past scratch");

    // Coherent 64-bit read across a low-word carry
`ifdef SYSID_UPTIME_EN
    dut1.uptime_q <= 64'h0000_0001_FFFF_FFFF;
`endif
    bus1(1, 0, 4'd3, 0, 0, UP ? 32'hFFFF_FFFF : 32'd0, "uptime lo coherent");
    repeat (4) @(negedge clk);
    bus1(1, 0, 4'd4, 0, 0, UP ? 32'h0000_0001 : 32'd0, "uptime hi snapshot");

    // 64-bit wrap to zero
`ifdef SYSID_UPTIME_EN
    dut1.uptime_q <= 64'hFFFF_FFFF_FFFF_FFFF;
`endif
    @(negedge clk);
    bus1(1, 0, 4'd3, 0, 0, 32'd0, "uptime lo wrapped");
    bus1(1, 0, 4'd4, 0, 0, 32'd0, "uptime hi wrapped");

    // Reset in the same cycle as a read
    reset = 1'b1;
    address1 = 4'd0; read1 = 1'b1;
    @(negedge clk);
    read1 = 1'b0;
    chk("reset-read valid", {31'd0, valid1}, 32'd0);
    chk("reset-read data", rdata1, 32'd0);
    reset = 1'b0;
    bus1(1, 0, 4'd8, 0, 0, 32'd0, "scratch8 after reset");

    repeat (3) @(negedge clk);
    chk("dut1 pending beats", q1.size(), 32'd0);
    chk("dut2 pending beats", q2.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1);
  end

endmodule
